// File: rtl/fft_sample_framer.sv
// ADC-to-FFT Avalon-ST framer: edge-detected capture into a show-ahead FIFO, FRAME_LEN-sample frames with sop/eop.
// Optional build macro FRAMER_DC_REMOVE_EN: store samples as signed offset-removed values instead of raw codes.
module fft_sample_framer #(
    parameter int DATA_W     = 12,
    parameter int OUT_W      = 12,
    parameter int FRAME_LEN  = 1024,
    parameter int PTS_W      = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_measure_done,
    input  logic              i_run,
    input  logic              i_clear_ovf,
    input  logic              i_sink_ready,
    output logic              o_sink_valid,
    output logic              o_sink_sop,
    output logic              o_sink_eop,
    output logic [OUT_W-1:0]  o_sink_real,
    output logic [OUT_W-1:0]  o_sink_imag,
    output logic [1:0]        o_sink_error,
    output logic [PTS_W-1:0]  o_fftpts_in,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [15:0]       o_frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // state | meaning
    // IDLE    | waiting for a rising edge with run=1 to start a frame
    // CAPTURE | frame in progress; run is ignored until word FRAME_LEN-1 is written
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_CAPTURE = 1'b1;

    logic [0:0]       r_state;
    logic             r_md_d1;
    logic [CW-1:0]    r_wr_cnt;
    logic [CW-1:0]    r_rd_cnt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [15:0]      r_frame_count;
    logic [OUT_W-1:0] r_mem [FIFO_DEPTH];

    logic             w_rise;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic             w_full;
    logic             w_eop;
    logic [OUT_W-1:0] w_conv;

`ifdef FRAMER_DC_REMOVE_EN
    // Subtracting mid-scale from an offset-binary code is an MSB flip; the signed cast sign-extends.
    logic signed [DATA_W-1:0] w_centered;
    assign w_centered = {~i_adc_data[DATA_W-1], i_adc_data[DATA_W-2:0]};
    assign w_conv     = OUT_W'(w_centered);
`else
    assign w_conv = OUT_W'(i_adc_data);
`endif

    assign w_rise     = i_measure_done & ~r_md_d1;
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = w_valid & i_sink_ready;
    assign w_push_req = w_rise & ((r_state == S_CAPTURE) | i_run);
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_eop      = w_valid & (r_rd_cnt == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_md_d1       <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_md_d1 <= i_measure_done;

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_cnt <= (r_rd_cnt == LAST_IDX) ? '0 : r_rd_cnt + 1'b1;
                if (w_eop)
                    r_frame_count <= r_frame_count + 1'b1;
            end

            // A rejected push leaves wr_cnt and state alone so the frame still gets FRAME_LEN samples.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_wr_cnt == LAST_IDX) begin
                    r_wr_cnt <= '0;
                    r_state  <= S_IDLE;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                    r_state  <= S_CAPTURE;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_push_req & ~w_push)
                r_overflow <= 1'b1;
            else if (i_clear_ovf)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_conv;
    end

    assign o_sink_valid  = w_valid;
    assign o_sink_sop    = w_valid & (r_rd_cnt == '0);
    assign o_sink_eop    = w_eop;
    assign o_sink_real   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_sink_imag   = '0;
    assign o_sink_error  = 2'b00;
    assign o_fftpts_in   = PTS_W'(FRAME_LEN);
    assign o_busy        = (r_state == S_CAPTURE);
    assign o_overflow    = r_overflow;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_fft_sample_framer.sv
// Self-checking bench for fft_sample_framer: queue-based frame model, conversion table, and corner-case sequences.
module tb_fft_sample_framer;

    localparam int DATA_W     = 12;
    localparam int OUT_W      = 12;
    localparam int FRAME_LEN  = 1024;
    localparam int PTS_W      = 11;
    localparam int FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] adc_data;
    logic              measure_done;
    logic              run;
    logic              clear_ovf;
    logic              sink_ready;
    logic              sink_valid, sink_sop, sink_eop;
    logic [OUT_W-1:0]  sink_real, sink_imag;
    logic [1:0]        sink_error;
    logic [PTS_W-1:0]  fftpts_in;
    logic              busy, overflow;
    logic [15:0]       frame_count;

    fft_sample_framer #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .FRAME_LEN(FRAME_LEN),
        .PTS_W(PTS_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_adc_data(adc_data),
        .i_measure_done(measure_done), .i_run(run), .i_clear_ovf(clear_ovf),
        .i_sink_ready(sink_ready), .o_sink_valid(sink_valid), .o_sink_sop(sink_sop),
        .o_sink_eop(sink_eop), .o_sink_real(sink_real), .o_sink_imag(sink_imag),
        .o_sink_error(sink_error), .o_fftpts_in(fftpts_in), .o_busy(busy),
        .o_overflow(overflow), .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: samples waiting for the sink, samples accepted in the current frame, pops in the current frame.
    logic [OUT_W-1:0] q[$];
    int  m_accepted = 0;
    int  m_popped   = 0;
    bit  m_in_frame = 0;
    bit  m_ovf      = 0;
    bit  m_prev_md  = 0;
    int  m_frames   = 0;

    typedef struct {
        logic [DATA_W-1:0] adc;
        logic [OUT_W-1:0]  exp_real;
    } conv_vec_t;

    function automatic logic [OUT_W-1:0] ref_conv(input logic [DATA_W-1:0] d);
        int v;
`ifdef FRAMER_DC_REMOVE_EN
        v = int'(d) - (1 << (DATA_W - 1));
`else
        v = int'(d);
`endif
        return v[OUT_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic md, input logic [DATA_W-1:0] d, input logic rn,
                              input logic clr, input logic rdy, input logic rst);
        bit rise, pop, want, room;
        if (rst) begin
            q.delete();
            m_accepted = 0; m_popped = 0; m_in_frame = 0;
            m_ovf = 0; m_prev_md = 0; m_frames = 0;
            return;
        end
        rise = md && !m_prev_md;
        m_prev_md = md;
        pop  = (q.size() > 0) && rdy;
        want = rise && (m_in_frame || rn);
        room = (q.size() < FIFO_DEPTH) || pop;
        if (pop) begin
            void'(q.pop_front());
            m_popped++;
            if (m_popped == FRAME_LEN) begin
                m_popped = 0;
                m_frames = (m_frames + 1) % 65536;
            end
        end
        if (clr) m_ovf = 0;
        if (want && !room) m_ovf = 1;
        if (want && room) begin
            q.push_back(ref_conv(d));
            m_accepted++;
            m_in_frame = 1;
            if (m_accepted == FRAME_LEN) begin
                m_accepted = 0;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit v;
        v = q.size() > 0;
        chk("valid", sink_valid, v);
        chk("real", sink_real, v ? q[0] : '0);
        chk("sop", sink_sop, v && (m_popped == 0));
        chk("eop", sink_eop, v && (m_popped == FRAME_LEN - 1));
        chk("busy", busy, m_in_frame);
        chk("overflow", overflow, m_ovf);
        chk("frame_count", frame_count, m_frames);
    endtask

    task automatic step(input logic md, input logic [DATA_W-1:0] d, input logic rn,
                        input logic clr, input logic rdy, input logic rst);
        measure_done = md; adc_data = d; run = rn;
        clear_ovf = clr; sink_ready = rdy; reset = rst;
        @(posedge clk);
        model_edge(md, d, rn, clr, rdy, rst);
        #1;
        compare_all();
    endtask

    // One conversion = rising edge then low, with value d.
    task automatic sample(input logic [DATA_W-1:0] d, input logic rn, input logic rdy);
        step(1'b1, d, rn, 1'b0, rdy, 1'b0);
        step(1'b0, d, rn, 1'b0, rdy, 1'b0);
    endtask

    conv_vec_t vecs[5];
    int        valid_cycles;

    initial begin
        vecs[0].adc = 12'h000; vecs[1].adc = 12'h800; vecs[2].adc = 12'hFFF;
        vecs[3].adc = 12'h123; vecs[4].adc = 12'h7FF;
`ifdef FRAMER_DC_REMOVE_EN
        vecs[0].exp_real = 12'h800; vecs[1].exp_real = 12'h000; vecs[2].exp_real = 12'h7FF;
        vecs[3].exp_real = 12'h923; vecs[4].exp_real = 12'hFFF;
`else
        vecs[0].exp_real = 12'h000; vecs[1].exp_real = 12'h800; vecs[2].exp_real = 12'hFFF;
        vecs[3].exp_real = 12'h123; vecs[4].exp_real = 12'h7FF;
`endif

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", sink_valid, 1'b0);
        chk("rst_fftpts", fftpts_in, 11'd1024);
        chk("rst_imag", sink_imag, 12'h000);
        chk("rst_error", sink_error, 2'b00);
        chk("rst_fc", frame_count, 16'd0);

        // Conversion table: each sample shows up one cycle after its edge
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vecs[i].adc, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("tbl_valid", sink_valid, 1'b1);
            chk("tbl_real", sink_real, vecs[i].exp_real);
            chk("tbl_sop", sink_sop, i == 0);
            step(1'b0, vecs[i].adc, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        // Reset mid-frame at sample 300
        for (int i = 5; i < 300; i++) sample(DATA_W'(i), 1'b1, 1'b1);
        chk("mid_busy", busy, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_valid", sink_valid, 1'b0);
        chk("mrst_fc", frame_count, 16'd0);

        // Full frame, adc_data = i
        for (int i = 0; i < FRAME_LEN; i++) begin
            step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 0) begin
                chk("ff_sop", sink_sop, 1'b1);
                chk("ff_first", sink_real, ref_conv(12'h000));
            end
            if (i == FRAME_LEN - 1) begin
                chk("ff_busy_fall", busy, 1'b0);
                chk("ff_eop", sink_eop, 1'b1);
                chk("ff_last", sink_real, ref_conv(12'd1023));
            end
            step(1'b0, DATA_W'(i), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("ff_fc", frame_count, 16'd1);

        // Backpressure: 5 samples, then 20 stalled cycles
        for (int i = 0; i < 5; i++) sample(DATA_W'(12'h100 + i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_hold_real", sink_real, ref_conv(12'h100));
            chk("bp_hold_sop", sink_sop, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("bp_order", sink_real, (i < 4) ? ref_conv(DATA_W'(12'h101 + i)) : '0);
        end

        // Overflow: 18 edges into a stalled 16-deep FIFO
        for (int i = 0; i < 18; i++) sample(DATA_W'(12'h200 + i), 1'b1, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_valid", sink_valid, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovf_clear", overflow, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf_drained", sink_valid, 1'b0);
        for (int i = 0; i < 2 * FRAME_LEN && m_in_frame; i++) sample(DATA_W'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf_frame_end", busy, 1'b0);
        chk("ovf_fc", frame_count, 16'd2);

        // Run gating: drop run at sample 500
        for (int i = 0; i < 500; i++) sample(DATA_W'(i), 1'b1, 1'b1);
        for (int i = 500; i < FRAME_LEN; i++) sample(DATA_W'(i), 1'b0, 1'b1);
        chk("rg_busy", busy, 1'b0);
        chk("rg_fc", frame_count, 16'd3);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 12'h3C3, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("rg_ignored", sink_valid, 1'b0);
            step(1'b0, 12'h3C3, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 12'h055, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rg_restart_sop", sink_sop, 1'b1);
        chk("rg_restart_busy", busy, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Edge detect: flag held high for 50 cycles yields one sample
        valid_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b1, 1'b0);
            if (sink_valid) valid_cycles++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
            if (sink_valid) valid_cycles++;
        end
        chk("edge_one_sample", valid_cycles, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 8000; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), (i == 4000));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_sample_framer.md
# fft_sample_framer

Stream framer between the ADC capture path (12-bit LTC2308 result plus its `wait_measure_done` flag) and the variable-streaming FFT core's Avalon-ST sink. It turns asynchronous-rate ADC conversions into contiguous FRAME_LEN-sample frames with correct `sink_sop`/`sink_eop`/`sink_valid` and respects `sink_ready` backpressure. It buffers conversions in a small FIFO and reports dropped samples. Run/stop gating happens only at frame boundaries.

## Interface
- `DATA_W`, 12, ADC sample width
- `OUT_W`, 12, FFT sink real/imag width, must be ≥ DATA_W
- `FRAME_LEN`, 1024, samples per frame; power of 2, ≤ 2^PTS_W − 1
- `PTS_W`, 11, width of `fftpts_in`
- `FIFO_DEPTH`, 16, sample buffer depth; power of 2, ≥ 2
- `clk`  in  1  system clock (CLOCK_50 domain, same as ADC controller)
- `reset`  in  1  synchronous, active-high reset
- `adc_data`  in  DATA_W  raw ADC result (ADCout)
- `measure_done`  in  1  ADC conversion-ready level flag (wait_measure_done)
- `run`  in  1  1 = capture frames, 0 = stop after the current frame (SW[8])
- `clear_ovf`  in  1  clears `overflow`
- `sink_ready`  in  1  FFT core ready
- `sink_valid`  out  1  sample valid
- `sink_sop` / `sink_eop`  out  1  first / last sample of frame
- `sink_real`  out  OUT_W  sample
- `sink_imag`  out  OUT_W  constant 0
- `sink_error`  out  2  constant 2'b00
- `fftpts_in`  out  PTS_W  constant FRAME_LEN
- `busy`  out  1  capture frame in progress
- `overflow`  out  1  sticky: sample dropped because FIFO full
- `frame_count`  out  16  frames fully delivered, wraps at 65535→0

## Operation
- Edge detect: `measure_done_d1` register. `rise = measure_done & ~measure_done_d1`. One sample per rising edge. A held-high flag produces no further samples.
- Capture side states:
  - IDLE: go to CAPTURE on `rise & run`. That sample is written as word 0, and `wr_cnt` becomes 1.
  - CAPTURE: each `rise` writes one word and increments `wr_cnt`. After word FRAME_LEN−1 is written, go to IDLE with `wr_cnt=0`. `run` is ignored mid-frame.
  - A `rise` in IDLE with `run=0` is discarded.
- Push rule: a push is accepted when FIFO count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Rejected push sets `overflow`. The sample is lost and `wr_cnt` does not advance, so the frame still contains FRAME_LEN samples.
  - `overflow` clears on `clear_ovf` or `reset`. A set and clear in the same cycle leaves it set.
- Output side (show-ahead FIFO):
  - `sink_valid = !empty`; pop on `sink_valid & sink_ready`.
  - `rd_cnt` increments per pop and wraps FRAME_LEN−1→0.
  - `sink_sop = sink_valid & (rd_cnt==0)`; `sink_eop = sink_valid & (rd_cnt==FRAME_LEN−1)`.
  - A pop with eop increments `frame_count`.
- While `sink_valid=1 & sink_ready=0`, `sink_real`, sop and eop are held stable.
- `busy` = state is CAPTURE.
- Reset values: all outputs 0 except `fftpts_in`=FRAME_LEN. FIFO is flushed, `wr_cnt=rd_cnt=0`, state IDLE, `measure_done_d1=0`.
- Reset mid-frame discards the partial frame. The next frame starts with sop. The FFT core must be reset alongside.

## Timing
- Latency: a sample whose `rise` is sampled at edge k is written at edge k. With the FIFO empty, `sink_valid` is 1 in the cycle after edge k.
- Throughput: one pop per cycle; one push per cycle max.
- Simultaneous push+pop on an empty FIFO: the pop does not occur because valid is 0. The push is accepted.
- Simultaneous push+pop on a full FIFO: both occur, and the count stays at FIFO_DEPTH.
- `frame_count` updates the cycle after the eop pop edge.

## Configuration
- `FRAMER_DC_REMOVE_EN` defined:
  - `sink_real` = adc_data − 2^(DATA_W−1), two's complement, sign-extended to OUT_W. For DATA_W=12 this is the MSB inverted.
  - Example: 0x800→0, 0xFFF→+2047, 0x000→−2048.
- Undefined: `sink_real` = adc_data zero-extended to OUT_W, or the raw bits when OUT_W=DATA_W.
- The conversion is applied at the FIFO write and adds no latency.

## Test plan
- Frame, DC removal: `run=1`, `sink_ready=1`, 1024 edges, adc_data=i → 1024 pops, sop on value 0x000 (−2048 with DC_REMOVE), eop on 1023, `frame_count`=1, `busy` falls after the 1024th write.
- Backpressure: `sink_ready=0` for 20 cycles after 5 samples → valid held, data/sop stable, no loss, order preserved after release.
- Overflow: `sink_ready=0`, 18 edges with FIFO_DEPTH=16 → 16 stored, `overflow`=1, frame still ends after 1024 accepted samples; `clear_ovf` → 0.
- Run gating: drop `run` at sample 500 → frame completes to eop, then edges ignored and `busy`=0; raise `run` → next edge starts a new frame with sop.
- Reset mid-frame: `reset` at sample 300 → outputs 0 next cycle; next frame's first pop has sop, `frame_count`=0.
- Edge detect: `measure_done` held high 50 cycles → exactly one sample captured.
